// File: rtl/exec_unit_pkg.sv
// exec_unit_pkg: shared encodings for the execute stage.
//   - forwarding selects (NO_FWD / FWD_MEM / FWD_WB)
//   - ALU source selects (PC vs rs1, IMM vs rs2)
//   - ALU op classes coming from the main decoder
//   - RV M-extension funct7 marker and funct3 codes
//   - mul/div FSM state encodings
//   - internal ALU control codes
package exec_unit_pkg;

  // Forwarding selects
  localparam logic [1:0] NO_FWD  = 2'd0;
  localparam logic [1:0] FWD_MEM = 2'd1;
  localparam logic [1:0] FWD_WB  = 2'd2;

  // ALU source selects
  localparam logic SRC_A_RS1 = 1'b0;
  localparam logic SRC_A_PC  = 1'b1;
  localparam logic SRC_B_RS2 = 1'b0;
  localparam logic SRC_B_IMM = 1'b1;

  // ALU op classes from the control unit
  localparam logic [3:0] ALU_OP_ADD    = 4'd0;  // loads, stores, AUIPC
  localparam logic [3:0] ALU_OP_BRANCH = 4'd1;  // conditional branch compare
  localparam logic [3:0] ALU_OP_R      = 4'd2;  // register-register
  localparam logic [3:0] ALU_OP_I      = 4'd3;  // register-immediate
  localparam logic [3:0] ALU_OP_LUI    = 4'd4;  // pass operand B
  localparam logic [3:0] ALU_OP_JAL    = 4'd5;  // link = PC+4, target = PC+IMM
  localparam logic [3:0] ALU_OP_JALR   = 4'd6;  // link = PC+4, target = rs1+IMM

  // M extension
  localparam logic [6:0] MD_FUNCT7 = 7'b0000001;
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  // Mul/div FSM states
  localparam logic [1:0] MD_IDLE = 2'd0;
  localparam logic [1:0] MD_BUSY = 2'd1;
  localparam logic [1:0] MD_DONE = 2'd2;

  // Internal ALU control
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB, ALU_LINK
  } aluCtrl_t;

endpackage

// File: rtl/exec_unit_muldiv_iter.sv
// muldiv_iter: iterative RV M-extension engine (shift-add multiply,
// restoring divide), one step per clock over XLEN steps.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   start         live M instruction present (acted on only in IDLE)
//   flush         abandon any operation, return to IDLE next cycle
//   funct3        M operation select
//   opA, opB      forwarded rs1/rs2, captured at issue
//   idle/busy/done  FSM state decodes
//   result        sign-corrected result, valid while done
// Build option FLINT_FAST_MUL_EN: multiplies finish in a single cycle
// (IDLE->DONE); divides stay iterative.
module muldiv_iter
  import exec_unit_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] opA,
  input  logic [XLEN-1:0] opB,
  output logic            idle,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  XMIN      = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt_p1;
  logic [2:0]       f3_p1;
  logic             negProd_p1, negRem_p1;
  logic [XLEN-1:0]  magB_p1;
  // accHi: product high half / partial remainder
  // accLo: multiplier being consumed / dividend shifting into quotient
  logic [XLEN-1:0]  accHi_p1, accLo_p1;
  logic [XLEN-1:0]  result_p2;

  // Issue-time decode
  logic            signA, signB, aNeg, bNeg, isMul, isRem, divZero, divOvf;
  logic [XLEN-1:0] magA, magB, specialRes;

  // Step datapath
  logic [XLEN:0]   mulSum, divShift, divDiff;
  logic            divGe;
  logic [XLEN-1:0] hiNext, loNext;

  function automatic logic [XLEN-1:0] fixSign(
    input logic [2:0]      f3,
    input logic            negProd,
    input logic            negRem,
    input logic [XLEN-1:0] hi,
    input logic [XLEN-1:0] lo
  );
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   res;
    // Sign applied to the full double-width product so the high half
    // receives the correct borrow.
    prod = negProd ? -{hi, lo} : {hi, lo};
    if (!f3[2])
      res = (f3 == F3_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    else if (f3[1])
      res = negRem ? -hi : hi;
    else
      res = negProd ? -lo : lo;
    return res;
  endfunction

  always_comb begin
    signA = 1'b0;
    signB = 1'b0;
    case (funct3)
      F3_MUL, F3_MULH: begin signA = 1'b1; signB = 1'b1; end
      F3_MULHSU:       signA = 1'b1;
      F3_MULHU:        ;
      F3_DIV, F3_REM:  begin signA = 1'b1; signB = 1'b1; end
      F3_DIVU, F3_REMU: ;
      default:         ;
    endcase
  end

  assign isMul   = ~funct3[2];
  assign isRem   = funct3[1];
  assign aNeg    = signA & opA[XLEN-1];
  assign bNeg    = signB & opB[XLEN-1];
  assign magA    = aNeg ? -opA : opA;
  assign magB    = bNeg ? -opB : opB;
  assign divZero = ~isMul & (opB == '0);
  assign divOvf  = ~isMul & signA & (opA == XMIN) & (opB == '1);

  // Divide by zero: q = all ones, r = dividend. Overflow: q = MIN, r = 0.
  assign specialRes = divZero ? (isRem ? opA : '1)
                              : (isRem ? '0  : opA);

`ifdef FLINT_FAST_MUL_EN
  logic [2*XLEN-1:0] fastProd;
  assign fastProd = {{XLEN{1'b0}}, magA} * {{XLEN{1'b0}}, magB};
`endif

  // Multiply step: add multiplicand when LSB of multiplier set, shift right.
  assign mulSum = {1'b0, accHi_p1} + (accLo_p1[0] ? {1'b0, magB_p1} : '0);

  // Restoring divide step: shift in next dividend bit, try subtract.
  assign divShift = {accHi_p1, accLo_p1[XLEN-1]};
  assign divDiff  = divShift - {1'b0, magB_p1};
  assign divGe    = ~divDiff[XLEN];

  always_comb begin
    if (f3_p1[2]) begin
      hiNext = divGe ? divDiff[XLEN-1:0] : divShift[XLEN-1:0];
      loNext = {accLo_p1[XLEN-2:0], divGe};
    end else begin
      hiNext = mulSum[XLEN:1];
      loNext = {mulSum[0], accLo_p1[XLEN-1:1]};
    end
  end

  // ---- Stage p1: capture at issue, iterate; stage p2: result register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= MD_IDLE;
      cnt_p1     <= '0;
      f3_p1      <= '0;
      negProd_p1 <= 1'b0;
      negRem_p1  <= 1'b0;
      magB_p1    <= '0;
      accHi_p1   <= '0;
      accLo_p1   <= '0;
      result_p2  <= '0;
    end else if (flush) begin
      state <= MD_IDLE;
    end else begin
      case (state)
        MD_IDLE: begin
          if (start) begin
            f3_p1      <= funct3;
            negProd_p1 <= aNeg ^ bNeg;
            negRem_p1  <= aNeg;
            magB_p1    <= magB;
            accHi_p1   <= '0;
            accLo_p1   <= magA;
            cnt_p1     <= '0;
            if (divZero | divOvf) begin
              result_p2 <= specialRes;
              state     <= MD_DONE;
            end
`ifdef FLINT_FAST_MUL_EN
            else if (isMul) begin
              result_p2 <= fixSign(funct3, aNeg ^ bNeg, aNeg,
                                   fastProd[2*XLEN-1:XLEN], fastProd[XLEN-1:0]);
              state     <= MD_DONE;
            end
`endif
            else begin
              state <= MD_BUSY;
            end
          end
        end
        MD_BUSY: begin
          accHi_p1 <= hiNext;
          accLo_p1 <= loNext;
          cnt_p1   <= cnt_p1 + CNT_W'(1);
          if (cnt_p1 == LAST_STEP) begin
            result_p2 <= fixSign(f3_p1, negProd_p1, negRem_p1, hiNext, loNext);
            state     <= MD_DONE;
          end
        end
        MD_DONE: state <= MD_IDLE;
        default: state <= MD_IDLE;
      endcase
    end
  end

  assign idle   = (state == MD_IDLE);
  assign busy   = (state == MD_BUSY);
  assign done   = (state == MD_DONE);
  assign result = result_p2;

endmodule

// File: rtl/exec_unit.sv
// exec_unit: execute stage between ID/EX and EX/MEM.
// Combinational forwarding, ALU source select, ALU control, ALU and
// branch/jump address generation, plus an iterative mul/div engine that
// holds the pipeline through o_stall while it works.
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_valid, i_flush        live instruction / kill in-flight instruction
//   i_funct7, i_funct3      instruction function fields
//   i_aluOp                 ALU op class from control
//   i_fwdRs1, i_fwdRs2      forwarding selects
//   i_aluSrcA, i_aluSrcB    PC-vs-rs1, IMM-vs-rs2
//   i_EXEC_rs1/rs2          register file operands
//   i_MEM_rd, i_WB_rd       forwarded results
//   i_PC, i_IMM             PC and immediate
//   o_aluOut                ALU result, or mul/div result in its DONE cycle
//   o_addrGenOut            branch/JAL/JALR target (JALR bit0 cleared)
//   o_rs2FwdOut             forwarded rs2 for stores
//   o_stall                 hold IF/ID/EX, bubble into MEM
//   o_mdBusy                mul/div engine not idle
// Build option FLINT_FAST_MUL_EN: single-cycle multiplies (see muldiv_iter).
module exec_unit
  import exec_unit_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  input  logic            i_flush,
  input  logic [6:0]      i_funct7,
  input  logic [2:0]      i_funct3,
  input  logic [3:0]      i_aluOp,
  input  logic [1:0]      i_fwdRs1,
  input  logic [1:0]      i_fwdRs2,
  input  logic            i_aluSrcA,
  input  logic            i_aluSrcB,
  input  logic [XLEN-1:0] i_EXEC_rs1,
  input  logic [XLEN-1:0] i_EXEC_rs2,
  input  logic [XLEN-1:0] i_MEM_rd,
  input  logic [XLEN-1:0] i_WB_rd,
  input  logic [XLEN-1:0] i_PC,
  input  logic [XLEN-1:0] i_IMM,
  output logic [XLEN-1:0] o_aluOut,
  output logic [XLEN-1:0] o_addrGenOut,
  output logic [XLEN-1:0] o_rs2FwdOut,
  output logic            o_stall,
  output logic            o_mdBusy
);

  localparam int SHW = $clog2(XLEN);

  logic [XLEN-1:0]        rs1Out, rs2Out, aluA, aluB, aluRes;
  logic signed [XLEN-1:0] aluASgn, aluBSgn;
  logic [SHW-1:0]         shamt;
  aluCtrl_t               aluCtrl;
  logic [XLEN-1:0]        addrBase, addrSum, mdResult;
  logic                   isJalr, isMD, mdIdle, mdInBusy, mdDone;

  // Operand forwarding
  always_comb begin
    case (i_fwdRs1)
      NO_FWD:  rs1Out = i_EXEC_rs1;
      FWD_MEM: rs1Out = i_MEM_rd;
      FWD_WB:  rs1Out = i_WB_rd;
      default: rs1Out = i_EXEC_rs1;
    endcase
    case (i_fwdRs2)
      NO_FWD:  rs2Out = i_EXEC_rs2;
      FWD_MEM: rs2Out = i_MEM_rd;
      FWD_WB:  rs2Out = i_WB_rd;
      default: rs2Out = i_EXEC_rs2;
    endcase
  end

  // ALU source selection
  always_comb begin
    case (i_aluSrcA)
      SRC_A_RS1: aluA = rs1Out;
      SRC_A_PC:  aluA = i_PC;
      default:   aluA = rs1Out;
    endcase
    case (i_aluSrcB)
      SRC_B_RS2: aluB = rs2Out;
      SRC_B_IMM: aluB = i_IMM;
      default:   aluB = rs2Out;
    endcase
  end

  assign o_rs2FwdOut = rs2Out;

  // ALU control
  always_comb begin
    aluCtrl = ALU_ADD;
    case (i_aluOp)
      ALU_OP_ADD: aluCtrl = ALU_ADD;
      ALU_OP_BRANCH: begin
        case (i_funct3[2:1])
          2'b10:   aluCtrl = ALU_SLT;   // BLT/BGE
          2'b11:   aluCtrl = ALU_SLTU;  // BLTU/BGEU
          default: aluCtrl = ALU_SUB;   // BEQ/BNE
        endcase
      end
      ALU_OP_R, ALU_OP_I: begin
        case (i_funct3)
          3'b000:  aluCtrl = (i_aluOp == ALU_OP_R && i_funct7[5]) ? ALU_SUB : ALU_ADD;
          3'b001:  aluCtrl = ALU_SLL;
          3'b010:  aluCtrl = ALU_SLT;
          3'b011:  aluCtrl = ALU_SLTU;
          3'b100:  aluCtrl = ALU_XOR;
          3'b101:  aluCtrl = i_funct7[5] ? ALU_SRA : ALU_SRL;
          3'b110:  aluCtrl = ALU_OR;
          default: aluCtrl = ALU_AND;
        endcase
      end
      ALU_OP_LUI:              aluCtrl = ALU_PASSB;
      ALU_OP_JAL, ALU_OP_JALR: aluCtrl = ALU_LINK;
      default:                 aluCtrl = ALU_ADD;
    endcase
  end

  // ALU
  assign aluASgn = aluA;
  assign aluBSgn = aluB;
  assign shamt   = aluB[SHW-1:0];

  always_comb begin
    aluRes = '0;
    case (aluCtrl)
      ALU_ADD:   aluRes = aluA + aluB;
      ALU_SUB:   aluRes = aluA - aluB;
      ALU_SLL:   aluRes = aluA << shamt;
      ALU_SLT:   aluRes = {{(XLEN-1){1'b0}}, (aluASgn < aluBSgn)};
      ALU_SLTU:  aluRes = {{(XLEN-1){1'b0}}, (aluA < aluB)};
      ALU_XOR:   aluRes = aluA ^ aluB;
      ALU_SRL:   aluRes = aluA >> shamt;
      ALU_SRA:   aluRes = aluASgn >>> shamt;
      ALU_OR:    aluRes = aluA | aluB;
      ALU_AND:   aluRes = aluA & aluB;
      ALU_PASSB: aluRes = aluB;
      ALU_LINK:  aluRes = i_PC + XLEN'(4);
      default:   aluRes = '0;
    endcase
  end

  // Branch / jump target
  assign isJalr       = (i_aluOp == ALU_OP_JALR);
  assign addrBase     = isJalr ? rs1Out : i_PC;
  assign addrSum      = addrBase + i_IMM;
  assign o_addrGenOut = isJalr ? {addrSum[XLEN-1:1], 1'b0} : addrSum;

  // Mul/div engine
  assign isMD = i_valid & (i_aluOp == ALU_OP_R) & (i_funct7 == MD_FUNCT7);

  muldiv_iter #(
    .XLEN  (XLEN),
    .CNT_W (CNT_W)
  ) uMulDiv (
    .clk    (i_clk),
    .rst    (i_rst),
    .start  (isMD),
    .flush  (i_flush),
    .funct3 (i_funct3),
    .opA    (rs1Out),
    .opB    (rs2Out),
    .idle   (mdIdle),
    .busy   (mdInBusy),
    .done   (mdDone),
    .result (mdResult)
  );

  // Stall covers the issue cycle and every BUSY cycle; DONE releases the
  // pipeline so the result flows into EX/MEM that same cycle.
  assign o_stall  = (mdIdle & isMD) | mdInBusy;
  assign o_mdBusy = ~mdIdle;
  assign o_aluOut = mdDone ? mdResult : aluRes;

endmodule

// File: tb/tb_exec_unit.sv
`timescale 1ns/1ps
module tb_exec_unit;
  import exec_unit_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_rst, i_valid, i_flush;
  logic [6:0]  i_funct7;
  logic [2:0]  i_funct3;
  logic [3:0]  i_aluOp;
  logic [1:0]  i_fwdRs1, i_fwdRs2;
  logic        i_aluSrcA, i_aluSrcB;
  logic [31:0] i_EXEC_rs1, i_EXEC_rs2, i_MEM_rd, i_WB_rd, i_PC, i_IMM;
  logic [31:0] o_aluOut, o_addrGenOut, o_rs2FwdOut;
  logic        o_stall, o_mdBusy;

  int checks = 0;
  int errors = 0;

  exec_unit #(.XLEN(32)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_flush(i_flush),
    .i_funct7(i_funct7), .i_funct3(i_funct3), .i_aluOp(i_aluOp),
    .i_fwdRs1(i_fwdRs1), .i_fwdRs2(i_fwdRs2),
    .i_aluSrcA(i_aluSrcA), .i_aluSrcB(i_aluSrcB),
    .i_EXEC_rs1(i_EXEC_rs1), .i_EXEC_rs2(i_EXEC_rs2),
    .i_MEM_rd(i_MEM_rd), .i_WB_rd(i_WB_rd), .i_PC(i_PC), .i_IMM(i_IMM),
    .o_aluOut(o_aluOut), .o_addrGenOut(o_addrGenOut), .o_rs2FwdOut(o_rs2FwdOut),
    .o_stall(o_stall), .o_mdBusy(o_mdBusy)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_idle();
    i_valid = 1'b0; i_flush = 1'b0;
    i_funct7 = 7'd0; i_funct3 = 3'd0; i_aluOp = ALU_OP_R;
    i_fwdRs1 = NO_FWD; i_fwdRs2 = NO_FWD;
    i_aluSrcA = SRC_A_RS1; i_aluSrcB = SRC_B_RS2;
    i_EXEC_rs1 = 32'd5; i_EXEC_rs2 = 32'd7;
    i_MEM_rd = 32'd0; i_WB_rd = 32'd0; i_PC = 32'd0; i_IMM = 32'd0;
  endtask

  // Issue one M op, count stall cycles (bounded), capture the DONE-cycle output.
  task automatic run_md(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        output int stallCyc, output logic [31:0] res);
    i_valid = 1'b1; i_aluOp = ALU_OP_R; i_funct7 = MD_FUNCT7; i_funct3 = f3;
    i_fwdRs1 = NO_FWD; i_fwdRs2 = NO_FWD; i_aluSrcA = SRC_A_RS1; i_aluSrcB = SRC_B_RS2;
    i_EXEC_rs1 = a; i_EXEC_rs2 = b;
    #1;
    stallCyc = 0;
    while (o_stall && stallCyc < 200) begin
      stallCyc++;
      tick();
    end
    res = o_aluOut;
    i_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    set_idle();
    i_rst = 1'b1;
    tick(); tick();
    i_rst = 1'b0;
    #1;
    checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", o_stall); end
    checks++; if (o_mdBusy !== 1'b0) begin errors++; $display("FAIL reset_mdBusy: got %b expected 0", o_mdBusy); end
    checks++; if (o_aluOut !== 32'd12) begin errors++; $display("FAIL reset_aluOut: got %h expected %h", o_aluOut, 32'd12); end
  endtask

  task automatic test_alu_fwd();
    set_idle();
    i_valid = 1'b1; i_fwdRs1 = FWD_MEM; i_MEM_rd = 32'd100;
    #1;
    checks++; if (o_aluOut !== 32'd107) begin errors++; $display("FAIL add_fwd_mem: got %h expected %h", o_aluOut, 32'd107); end
    checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL add_stall: got %b expected 0", o_stall); end
    i_fwdRs2 = FWD_WB; i_WB_rd = 32'd20;
    #1;
    checks++; if (o_aluOut !== 32'd120) begin errors++; $display("FAIL add_fwd_wb: got %h expected %h", o_aluOut, 32'd120); end
    checks++; if (o_rs2FwdOut !== 32'd20) begin errors++; $display("FAIL rs2_fwd_out: got %h expected %h", o_rs2FwdOut, 32'd20); end
    i_fwdRs2 = NO_FWD; i_funct7 = 7'b0100000;
    #1;
    checks++; if (o_aluOut !== 32'd93) begin errors++; $display("FAIL sub: got %h expected %h", o_aluOut, 32'd93); end
    i_fwdRs1 = NO_FWD; i_funct7 = 7'd0; i_aluOp = ALU_OP_I; i_aluSrcB = SRC_B_IMM; i_IMM = 32'hFFFF_FFFD;
    #1;
    checks++; if (o_aluOut !== 32'd2) begin errors++; $display("FAIL addi_neg: got %h expected %h", o_aluOut, 32'd2); end
    set_idle();
    tick();
  endtask

  task automatic test_mul();
    int cyc;
    logic [31:0] r;
    run_md(F3_MUL, 32'hFFFF_FFFF, 32'd2, cyc, r);
    checks++; if (r !== 32'hFFFF_FFFE) begin errors++; $display("FAIL mul_lo: got %h expected %h", r, 32'hFFFF_FFFE); end
    checks++; if (cyc !== 33) begin errors++; $display("FAIL mul_stall_cycles: got %0d expected 33", cyc); end
    run_md(F3_MULHU, 32'hFFFF_FFFF, 32'd2, cyc, r);
    checks++; if (r !== 32'h0000_0001) begin errors++; $display("FAIL mulhu: got %h expected %h", r, 32'h1); end
    run_md(F3_MULH, 32'hFFFF_FFFF, 32'd2, cyc, r);
    checks++; if (r !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mulh: got %h expected %h", r, 32'hFFFF_FFFF); end
    run_md(F3_MULHSU, 32'hFFFF_FFFF, 32'd2, cyc, r);
    checks++; if (r !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mulhsu: got %h expected %h", r, 32'hFFFF_FFFF); end
    run_md(F3_MULH, 32'h8000_0000, 32'h8000_0000, cyc, r);
    checks++; if (r !== 32'h4000_0000) begin errors++; $display("FAIL mulh_min_min: got %h expected %h", r, 32'h4000_0000); end
  endtask

  task automatic test_div();
    int cyc;
    logic [31:0] r;
    run_md(F3_DIV, 32'hFFFF_FFF9, 32'd2, cyc, r);
    checks++; if (r !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_neg: got %h expected %h", r, 32'hFFFF_FFFD); end
    checks++; if (cyc !== 33) begin errors++; $display("FAIL div_stall_cycles: got %0d expected 33", cyc); end
    run_md(F3_REM, 32'hFFFF_FFF9, 32'd2, cyc, r);
    checks++; if (r !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rem_neg: got %h expected %h", r, 32'hFFFF_FFFF); end
    run_md(F3_REM, 32'd7, 32'hFFFF_FFFE, cyc, r);
    checks++; if (r !== 32'd1) begin errors++; $display("FAIL rem_divisor_neg: got %h expected %h", r, 32'd1); end
    run_md(F3_DIVU, 32'd7, 32'd0, cyc, r);
    checks++; if (r !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divu_by_zero: got %h expected %h", r, 32'hFFFF_FFFF); end
    checks++; if (cyc !== 1) begin errors++; $display("FAIL divu_zero_stall: got %0d expected 1", cyc); end
    run_md(F3_REMU, 32'd7, 32'd0, cyc, r);
    checks++; if (r !== 32'd7) begin errors++; $display("FAIL remu_by_zero: got %h expected %h", r, 32'd7); end
    run_md(F3_REM, 32'h8000_0000, 32'hFFFF_FFFF, cyc, r);
    checks++; if (r !== 32'd0) begin errors++; $display("FAIL rem_overflow: got %h expected %h", r, 32'd0); end
    checks++; if (cyc !== 1) begin errors++; $display("FAIL rem_overflow_stall: got %0d expected 1", cyc); end
    run_md(F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, cyc, r);
    checks++; if (r !== 32'h8000_0000) begin errors++; $display("FAIL div_overflow: got %h expected %h", r, 32'h8000_0000); end
  endtask

  task automatic test_operand_capture();
    int cyc;
    set_idle();
    i_valid = 1'b1; i_funct7 = MD_FUNCT7; i_funct3 = F3_DIVU;
    i_fwdRs1 = FWD_MEM; i_MEM_rd = 32'd100; i_EXEC_rs1 = 32'd0; i_EXEC_rs2 = 32'd3;
    #1;
    cyc = 0;
    while (o_stall && cyc < 200) begin
      cyc++;
      tick();
      if (cyc == 5) i_MEM_rd = 32'h0000_DEAD;
    end
    checks++; if (o_aluOut !== 32'd33) begin errors++; $display("FAIL capture_divu: got %h expected %h", o_aluOut, 32'd33); end
    checks++; if (cyc !== 33) begin errors++; $display("FAIL capture_stall_cycles: got %0d expected 33", cyc); end
    set_idle();
    tick();
  endtask

  // useRst=0 aborts with i_flush, useRst=1 aborts with i_rst.
  task automatic test_abort(input bit useRst);
    set_idle();
    i_valid = 1'b1; i_funct7 = MD_FUNCT7; i_funct3 = F3_MUL;
    i_EXEC_rs1 = 32'd3; i_EXEC_rs2 = 32'd5;
    #1;
    for (int i = 0; i < 10; i++) tick();
    checks++; if (o_stall !== 1'b1) begin errors++; $display("FAIL abort%0d_busy_stall: got %b expected 1", useRst, o_stall); end
    if (useRst) i_rst = 1'b1; else i_flush = 1'b1;
    i_valid = 1'b0;
    tick();
    i_rst = 1'b0; i_flush = 1'b0;
    #1;
    checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL abort%0d_stall: got %b expected 0", useRst, o_stall); end
    checks++; if (o_mdBusy !== 1'b0) begin errors++; $display("FAIL abort%0d_mdBusy: got %b expected 0", useRst, o_mdBusy); end
    i_valid = 1'b1; i_funct7 = 7'd0; i_funct3 = 3'd0; i_EXEC_rs1 = 32'd5; i_EXEC_rs2 = 32'd7;
    #1;
    checks++; if (o_aluOut !== 32'd12) begin errors++; $display("FAIL abort%0d_next_add: got %h expected %h", useRst, o_aluOut, 32'd12); end
    tick();
    checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL abort%0d_add_stall: got %b expected 0", useRst, o_stall); end
    set_idle();
    tick();
  endtask

  task automatic test_jump();
    set_idle();
    i_valid = 1'b1; i_aluOp = ALU_OP_JALR; i_EXEC_rs1 = 32'h1001; i_IMM = 32'd4; i_PC = 32'h100;
    #1;
    checks++; if (o_addrGenOut !== 32'h1004) begin errors++; $display("FAIL jalr_target: got %h expected %h", o_addrGenOut, 32'h1004); end
    checks++; if (o_aluOut !== 32'h104) begin errors++; $display("FAIL jalr_link: got %h expected %h", o_aluOut, 32'h104); end
    i_aluOp = ALU_OP_JAL; i_PC = 32'h200; i_IMM = 32'hFFFF_FFF8;
    #1;
    checks++; if (o_addrGenOut !== 32'h1F8) begin errors++; $display("FAIL jal_target: got %h expected %h", o_addrGenOut, 32'h1F8); end
    i_aluOp = ALU_OP_BRANCH; i_IMM = 32'h11;
    #1;
    checks++; if (o_addrGenOut !== 32'h211) begin errors++; $display("FAIL branch_target: got %h expected %h", o_addrGenOut, 32'h211); end
    set_idle();
    tick();
  endtask

  initial begin
    i_rst = 1'b0;
    set_idle();
    test_reset();
    test_alu_fwd();
    test_mul();
    test_div();
    test_operand_capture();
    test_abort(1'b0);
    test_abort(1'b1);
    test_jump();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
